// File: rtl/tape_prefetch.sv
// Tape image prefetcher: streams SDRAM tape-port reads into a byte FIFO
// and forwards download writes through the same toggle-ack port.
module tape_prefetch #(
  parameter int DEPTH = 8,
  parameter int AW    = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [AW-1:0]          tape_len,
  input  logic                   dl_wr,
  input  logic [AW-1:0]          dl_addr,
  input  logic [7:0]             dl_data,
  output logic                   dl_busy,
  output logic                   dl_overrun,
  output logic [AW-1:0]          tape_addr,
  output logic [7:0]             tape_din,
  output logic                   tape_rd,
  output logic                   tape_wr,
  input  logic                   tape_ack,
  input  logic [7:0]             tape_dout,
  output logic [7:0]             data,
  output logic                   data_valid,
  input  logic                   rd_strobe,
  output logic                   eof,
  output logic [$clog2(DEPTH):0] level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD,
    S_WR
  } state_t;

  state_t        state_q;
  logic          ack_ref_q;
  logic          running_q;
  logic          discard_q;
  logic          eof_q;
  logic [AW-1:0] len_q;
  logic [AW-1:0] rd_ptr_q;
  logic          dl_busy_q;
  logic          dl_overrun_q;
  logic [AW-1:0] dl_addr_q;
  logic [7:0]    dl_data_q;
  logic          tape_rd_q;
  logic          tape_wr_q;
  logic [AW-1:0] tape_addr_q;
  logic [7:0]    tape_din_q;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wp_q;
  logic [PW-1:0] rp_q;
  logic [LW-1:0] level_q;

  logic ack_seen;
  logic can_rd;
  logic push;
  logic pop;

  assign ack_seen = tape_ack != ack_ref_q;
  assign can_rd   = running_q && !stop && !start
                 && (rd_ptr_q < len_q)
                 && (level_q < LW'(DEPTH));
  // a restart swallows a byte landing in the same cycle
  assign push = (state_q == S_RD) && ack_seen
             && !discard_q && !start;
  assign pop  = rd_strobe && (level_q != '0) && !start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ack_ref_q    <= 1'b0;
      running_q    <= 1'b0;
      discard_q    <= 1'b0;
      eof_q        <= 1'b0;
      len_q        <= '0;
      rd_ptr_q     <= '0;
      dl_busy_q    <= 1'b0;
      dl_overrun_q <= 1'b0;
      dl_addr_q    <= '0;
      dl_data_q    <= '0;
      tape_rd_q    <= 1'b0;
      tape_wr_q    <= 1'b0;
      tape_addr_q  <= '0;
      tape_din_q   <= '0;
    end else begin
      if (dl_wr) begin
        if (dl_busy_q) begin
          dl_overrun_q <= 1'b1;
        end else begin
          dl_busy_q <= 1'b1;
          dl_addr_q <= dl_addr;
          dl_data_q <= dl_data;
        end
      end
      if (start) begin
        running_q    <= 1'b1;
        len_q        <= tape_len;
        rd_ptr_q     <= '0;
        dl_overrun_q <= 1'b0;
      end else if (stop) begin
        running_q <= 1'b0;
      end
      eof_q <= running_q && (rd_ptr_q >= len_q)
            && (level_q == '0) && (state_q == S_IDLE);
      unique case (state_q)
        S_IDLE: begin
          ack_ref_q <= tape_ack;
          if (dl_busy_q) begin
            state_q     <= S_WR;
            tape_wr_q   <= 1'b1;
            tape_addr_q <= dl_addr_q;
            tape_din_q  <= dl_data_q;
          end else if (can_rd) begin
            state_q     <= S_RD;
            tape_rd_q   <= 1'b1;
            tape_addr_q <= rd_ptr_q;
          end
        end
        S_RD: begin
          if (ack_seen) begin
            state_q   <= S_IDLE;
            tape_rd_q <= 1'b0;
            discard_q <= 1'b0;
            if (!discard_q && !start && (rd_ptr_q < len_q))
              rd_ptr_q <= rd_ptr_q + AW'(1);
          end else if (start) begin
            discard_q <= 1'b1;
          end
        end
        S_WR: begin
          if (ack_seen) begin
            state_q   <= S_IDLE;
            tape_wr_q <= 1'b0;
            dl_busy_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (start) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        mem_q[wp_q] <= tape_dout;
        wp_q        <= wp_q + PW'(1);
      end
      if (pop)
        rp_q <= rp_q + PW'(1);
      if (push && !pop)
        level_q <= level_q + LW'(1);
      else if (pop && !push)
        level_q <= level_q - LW'(1);
    end
  end

  assign dl_busy    = dl_busy_q;
  assign dl_overrun = dl_overrun_q;
  assign tape_addr  = tape_addr_q;
  assign tape_din   = tape_din_q;
  assign tape_rd    = tape_rd_q;
  assign tape_wr    = tape_wr_q;
  assign data       = mem_q[rp_q];
  assign data_valid = level_q != '0;
  assign eof        = eof_q;
  assign level      = level_q;

endmodule

// File: tb/tb_tape_prefetch.sv
// Bench for tape_prefetch: 8-phase SDRAM slot model with toggle ack,
// scoreboards for port requests and popped bytes.
module tb_tape_prefetch;

  localparam int DEPTH = 8;
  localparam int AW    = 23;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          stop;
  logic [AW-1:0] tape_len;
  logic          dl_wr;
  logic [AW-1:0] dl_addr;
  logic [7:0]    dl_data;
  logic          dl_busy;
  logic          dl_overrun;
  logic [AW-1:0] tape_addr;
  logic [7:0]    tape_din;
  logic          tape_rd;
  logic          tape_wr;
  logic          tape_ack = 1'b0;
  logic [7:0]    tape_dout = 8'h00;
  logic [7:0]    data;
  logic          data_valid;
  logic          rd_strobe;
  logic          eof;
  logic [3:0]    level;

  tape_prefetch #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .tape_len   (tape_len),
    .dl_wr      (dl_wr),
    .dl_addr    (dl_addr),
    .dl_data    (dl_data),
    .dl_busy    (dl_busy),
    .dl_overrun (dl_overrun),
    .tape_addr  (tape_addr),
    .tape_din   (tape_din),
    .tape_rd    (tape_rd),
    .tape_wr    (tape_wr),
    .tape_ack   (tape_ack),
    .tape_dout  (tape_dout),
    .data       (data),
    .data_valid (data_valid),
    .rd_strobe  (rd_strobe),
    .eof        (eof),
    .level      (level)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // SDRAM slot model: sample at phase 0, ack toggles at phase 6
  logic [2:0]    ph_q = 3'd0;
  logic          busy_m = 1'b0;
  logic          iswr_m = 1'b0;
  logic [AW-1:0] addr_m = '0;
  logic [7:0]    din_m = '0;
  logic          ack_chk = 1'b0;
  int            wr_cnt = 0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;

  always @(posedge clk) begin
    ph_q <= ph_q + 3'd1;
    if (ph_q == 3'd0) begin
      ack_chk <= 1'b0;
      if (!busy_m && (tape_rd || tape_wr)) begin
        busy_m <= 1'b1;
        iswr_m <= tape_wr;
        addr_m <= tape_addr;
        din_m  <= tape_din;
      end
    end
    if (ph_q == 3'd6 && busy_m) begin
      busy_m   <= 1'b0;
      tape_ack <= ~tape_ack;
      ack_chk  <= 1'b1;
      if (iswr_m) begin
        wr_cnt  <= wr_cnt + 1;
        wr_addr <= addr_m;
        wr_data <= din_m;
      end else begin
        tape_dout <= 8'h10 + addr_m[7:0];
      end
    end
  end

  logic [31:0] req_q[$];
  logic [7:0]  dat_q[$];
  logic        prev_req = 1'b0;

  task automatic exp_rd(input int a);
    req_q.push_back({1'b0, AW'(a), 8'h00});
  endtask

  task automatic exp_wr(input int a, input logic [7:0] d);
    req_q.push_back({1'b1, AW'(a), d});
  endtask

  task automatic exp_dat(input int first, input int n);
    for (int i = 0; i < n; i++)
      dat_q.push_back(8'(first + i));
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_req <= 1'b0;
    end else begin
      if ((tape_rd || tape_wr) && !prev_req) begin
        if (req_q.size() == 0)
          chk("unexpected_req", {tape_wr, tape_addr, tape_din}, 32'h0);
        else
          chk("req", {tape_wr, tape_addr, tape_wr ? tape_din : 8'h00},
              req_q.pop_front());
      end
      prev_req <= tape_rd || tape_wr;
      if (tape_rd || tape_wr)
        chk("both_req", {31'd0, tape_rd & tape_wr}, 32'd0);
      if (ph_q == 3'd0 && ack_chk)
        chk("req_low_ph0", {31'd0, tape_rd | tape_wr}, 32'd0);
      if (rd_strobe && data_valid) begin
        if (dat_q.size() == 0)
          chk("unexpected_pop", {24'd0, data}, 32'hFFFF);
        else
          chk("pop_data", {24'd0, data}, {24'd0, dat_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input int len);
    tape_len = AW'(len);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic pop_n(input int n);
    int got = 0;
    int t = 0;
    while (got < n && t < 2000) begin
      if (data_valid) begin
        rd_strobe = 1'b1;
        got++;
      end else begin
        rd_strobe = 1'b0;
      end
      cyc(1);
      t++;
    end
    rd_strobe = 1'b0;
    chk("pop_count", got, n);
  endtask

  task automatic wait_eof(input int b);
    int t = 0;
    while (!eof && t < b) begin
      cyc(1);
      t++;
    end
    chk("eof_wait", {31'd0, eof}, 32'd1);
  endtask

  task automatic wait_level(input int l, input int b);
    int t = 0;
    while (32'(level) != l && t < b) begin
      cyc(1);
      t++;
    end
    chk("level_wait", {28'd0, level}, l);
  endtask

  task automatic wait_rd(input logic v, input int b);
    int t = 0;
    while (tape_rd !== v && t < b) begin
      cyc(1);
      t++;
    end
    chk("rd_wait", {31'd0, tape_rd}, {31'd0, v});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic pw;
    rst_n = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    tape_len = '0;
    dl_wr = 1'b0;
    dl_addr = '0;
    dl_data = '0;
    rd_strobe = 1'b0;
    cyc(3);
    chk("rst_rd", {31'd0, tape_rd}, 0);
    chk("rst_wr", {31'd0, tape_wr}, 0);
    chk("rst_valid", {31'd0, data_valid}, 0);
    chk("rst_level", {28'd0, level}, 0);
    chk("rst_eof", {31'd0, eof}, 0);
    rst_n = 1'b1;
    cyc(2);

    // basic read: fills to DEPTH then stalls
    for (int i = 0; i < 16; i++)
      exp_rd(i);
    exp_dat(8'h10, 16);
    pulse_start(16);
    cyc(220);
    chk("basic_rd_low", {31'd0, tape_rd}, 0);
    chk("basic_level", {28'd0, level}, 8);
    chk("basic_head", {24'd0, data}, 32'h10);
    chk("basic_reqs_left", req_q.size(), 8);

    // drain
    pop_n(16);
    wait_eof(200);
    chk("drain_level", {28'd0, level}, 0);
    cyc(40);
    chk("drain_reqs_left", req_q.size(), 0);
    chk("drain_rd_low", {31'd0, tape_rd}, 0);

    // download priority and overrun
    exp_rd(0);
    exp_wr(32'h1234, 8'hA5);
    exp_rd(1);
    exp_rd(2);
    exp_rd(3);
    exp_dat(8'h10, 4);
    pulse_start(4);
    wait_rd(1'b1, 40);
    dl_wr = 1'b1;
    dl_addr = AW'(32'h1234);
    dl_data = 8'hA5;
    cyc(1);
    dl_addr = AW'(32'h2222);
    dl_data = 8'h5A;
    cyc(1);
    dl_wr = 1'b0;
    chk("dl_busy_set", {31'd0, dl_busy}, 1);
    chk("dl_overrun_set", {31'd0, dl_overrun}, 1);
    t = 0;
    pw = tape_wr;
    while (dl_busy && t < 100) begin
      pw = tape_wr;
      cyc(1);
      t++;
    end
    chk("dl_busy_fall", {31'd0, dl_busy}, 0);
    chk("dl_wr_before_fall", {31'd0, pw}, 1);
    chk("dl_wr_at_fall", {31'd0, tape_wr}, 0);
    chk("dl_wr_count", wr_cnt, 1);
    chk("dl_wr_addr", {9'd0, wr_addr}, 32'h1234);
    chk("dl_wr_data", {24'd0, wr_data}, 32'hA5);
    pop_n(4);
    wait_eof(200);
    chk("dl_wr_count_end", wr_cnt, 1);

    // restart during in-flight read
    exp_rd(0);
    exp_rd(1);
    exp_rd(2);
    exp_rd(0);
    exp_dat(8'h10, 1);
    pulse_start(16);
    chk("start_clr_overrun", {31'd0, dl_overrun}, 0);
    t = 0;
    while (!(tape_rd && tape_addr == AW'(2)) && t < 200) begin
      cyc(1);
      t++;
    end
    chk("rs_rd2", {31'd0, tape_rd}, 1);
    cyc(3);
    pulse_start(16);
    chk("rs_level0", {28'd0, level}, 0);
    chk("rs_valid0", {31'd0, data_valid}, 0);
    wait_rd(1'b0, 40);
    cyc(2);
    chk("rs_discard", {28'd0, level}, 0);
    wait_level(1, 60);
    pulse_stop();
    pop_n(1);
    cyc(40);
    chk("rs_reqs_left", req_q.size(), 0);

    // stop after 3 bytes
    exp_rd(0);
    exp_rd(1);
    exp_rd(2);
    exp_dat(8'h10, 3);
    pulse_start(16);
    wait_level(3, 200);
    pulse_stop();
    cyc(40);
    chk("stop_level", {28'd0, level}, 3);
    chk("stop_rd_low", {31'd0, tape_rd}, 0);
    pop_n(3);
    chk("stop_level0", {28'd0, level}, 0);
    chk("stop_eof", {31'd0, eof}, 0);

    // zero length
    pulse_start(0);
    chk("zero_eof_1clk", {31'd0, eof}, 0);
    cyc(1);
    chk("zero_eof_2clk", {31'd0, eof}, 1);
    cyc(40);
    chk("zero_rd_low", {31'd0, tape_rd}, 0);
    chk("zero_eof_hold", {31'd0, eof}, 1);

    // reset mid-read
    exp_rd(0);
    pulse_start(16);
    wait_rd(1'b1, 40);
    cyc(2);
    rst_n = 1'b0;
    #1;
    chk("mr_rd", {31'd0, tape_rd}, 0);
    chk("mr_wr", {31'd0, tape_wr}, 0);
    chk("mr_addr", {9'd0, tape_addr}, 0);
    chk("mr_din", {24'd0, tape_din}, 0);
    chk("mr_data", {24'd0, data}, 0);
    chk("mr_valid", {31'd0, data_valid}, 0);
    chk("mr_level", {28'd0, level}, 0);
    chk("mr_eof", {31'd0, eof}, 0);
    chk("mr_busy", {31'd0, dl_busy}, 0);
    chk("mr_overrun", {31'd0, dl_overrun}, 0);
    cyc(20);
    rst_n = 1'b1;
    cyc(20);
    chk("mr_idle_rd", {31'd0, tape_rd}, 0);
    exp_rd(0);
    exp_rd(1);
    exp_dat(8'h10, 2);
    pulse_start(2);
    pop_n(2);
    wait_eof(200);

    cyc(10);
    chk("end_req_q", req_q.size(), 0);
    chk("end_dat_q", dat_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
